pipe_hazard_ctrl: RTL and testbench

Central hazard and redirect controller for the 5-stage FE/DE/AGEX/MEM/WB pipeline. It holds a per-register pending-write scoreboard and generates the RAW-hazard stall for DE. It also sequences branch resolution: it holds the front end while a branch is in flight, then issues a one-cycle redirect and squash to FE/DE. It replaces the ad-hoc stall/redirect wiring between stages with one owner.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, FSM encoding and stage-bus layouts for the pipeline hazard/redirect controller.
package pipe_hazard_ctrl_pkg;

   localparam int NUM_REGS  = 16;
   localparam int REG_IDX_W = 4;
   localparam int CNT_W     = 2;
   localparam int PC_W      = 32;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_BR_WAIT  = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   // Field order is the flat wire order used on the FE side of the bundle.
   typedef struct packed {
      logic            stall;
      logic            redirect_valid;
      logic            squash;
      logic [PC_W-1:0] redirect_pc;
   } from_hz_to_fe_t;

   typedef struct packed {
      logic stall;
   } from_hz_to_de_t;

   localparam int FROM_HZ_TO_FE_W = $bits(from_hz_to_fe_t);
   localparam int FROM_HZ_TO_DE_W = $bits(from_hz_to_de_t);

   function automatic logic [CNT_W-1:0] cnt_max();
      return {CNT_W{1'b1}};
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-write counters plus the RAW and counter-saturation hazard detection for DE.
module pipe_scoreboard
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue,
   input  logic [REG_IDX_W-1:0] de_src1,
   input  logic [REG_IDX_W-1:0] de_src2,
   input  logic                 de_src1_used,
   input  logic                 de_src2_used,
   input  logic [REG_IDX_W-1:0] de_dst,
   input  logic                 de_wr_en,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_dst,
   input  logic                 wb_wr_en,
   output logic [NUM_REGS-1:0]  busy_vec,
   output logic                 raw_hz,
   output logic                 sat_hz
);

   logic [CNT_W-1:0] w_cnt [NUM_REGS];
   logic             w_wb_wr;
   logic             w_hz1;
   logic             w_hz2;

   assign w_wb_wr = wb_valid & wb_wr_en;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign w_cnt[gi] = '0;
         end else begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = issue & de_wr_en & (de_dst == REG_IDX_W'(gi));
            assign w_dec = w_wb_wr & (wb_dst == REG_IDX_W'(gi));

            always_ff @(posedge clk) begin
               if (reset) begin
                  r_cnt <= '0;
               end else if (w_inc & !w_dec & (r_cnt != cnt_max())) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (w_dec & !w_inc & (r_cnt != '0)) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end

            assign w_cnt[gi] = r_cnt;

            a_no_dec_at_zero: assert property (@(posedge clk) disable iff (reset)
               !(w_dec & !w_inc & (r_cnt == '0)));
         end
         assign busy_vec[gi] = (w_cnt[gi] != '0);
      end
   endgenerate

   // Register file is write-first, so a retiring last writer already satisfies the read.
   assign w_hz1 = de_src1_used & (w_cnt[de_src1] != '0)
                & !(w_wb_wr & (wb_dst == de_src1) & (w_cnt[de_src1] == CNT_W'(1)));
   assign w_hz2 = de_src2_used & (w_cnt[de_src2] != '0)
                & !(w_wb_wr & (wb_dst == de_src2) & (w_cnt[de_src2] == CNT_W'(1)));

   assign raw_hz = w_hz1 | w_hz2;
   assign sat_hz = de_wr_en & (w_cnt[de_dst] == cnt_max());

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect controller: scoreboard stalls plus branch hold/redirect FSM.
// Optional stall statistics counters are built only when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 de_valid,
   input  logic [REG_IDX_W-1:0] de_src1,
   input  logic [REG_IDX_W-1:0] de_src2,
   input  logic                 de_src1_used,
   input  logic                 de_src2_used,
   input  logic [REG_IDX_W-1:0] de_dst,
   input  logic                 de_wr_en,
   input  logic                 de_is_br,
   input  logic                 agex_br_resolve,
   input  logic                 agex_br_taken,
   input  logic [PC_W-1:0]      agex_br_target,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_dst,
   input  logic                 wb_wr_en,
   output logic                 stall_fe,
   output logic                 stall_de,
   output logic                 redirect_valid,
   output logic [PC_W-1:0]      redirect_pc,
   output logic                 squash_fe_de,
   output logic [NUM_REGS-1:0]  busy_vec,
   output logic [31:0]          raw_stall_cnt,
   output logic [31:0]          br_stall_cnt
);

   logic [1:0]                 r_state;
   logic [1:0]                 w_state_next;
   logic [PC_W-1:0]            r_target;
   logic                       w_raw_hz;
   logic                       w_sat_hz;
   logic                       w_stall_de;
   logic                       w_stall_fe;
   logic                       w_redir;
   logic                       w_issue;
   from_hz_to_fe_t             w_to_fe;
   from_hz_to_de_t             w_to_de;
   logic [FROM_HZ_TO_FE_W-1:0] w_fe_bus;
   logic [FROM_HZ_TO_DE_W-1:0] w_de_bus;

   pipe_scoreboard u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .issue        (w_issue),
      .de_src1      (de_src1),
      .de_src2      (de_src2),
      .de_src1_used (de_src1_used),
      .de_src2_used (de_src2_used),
      .de_dst       (de_dst),
      .de_wr_en     (de_wr_en),
      .wb_valid     (wb_valid),
      .wb_dst       (wb_dst),
      .wb_wr_en     (wb_wr_en),
      .busy_vec     (busy_vec),
      .raw_hz       (w_raw_hz),
      .sat_hz       (w_sat_hz)
   );

   always_comb begin
      w_stall_de = 1'b0;
      w_stall_fe = 1'b0;
      w_redir    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_stall_de = de_valid & (w_raw_hz | w_sat_hz);
            w_stall_fe = w_stall_de;
         end
         ST_BR_WAIT: begin
            w_stall_de = 1'b1;
            w_stall_fe = 1'b1;
         end
         ST_REDIRECT: begin
            w_stall_de = 1'b1;
            w_redir    = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_issue = de_valid & !w_stall_de;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:      if (w_issue & de_is_br) w_state_next = ST_BR_WAIT;
         ST_BR_WAIT:  if (agex_br_resolve) w_state_next = agex_br_taken ? ST_REDIRECT : ST_RUN;
         ST_REDIRECT: w_state_next = ST_RUN;
         default:     w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_RUN;
         r_target <= '0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_BR_WAIT) & agex_br_resolve & agex_br_taken) begin
            r_target <= agex_br_target;
         end
      end
   end

   assign w_to_fe.stall          = w_stall_fe;
   assign w_to_fe.redirect_valid = w_redir;
   assign w_to_fe.squash         = w_redir;
   assign w_to_fe.redirect_pc    = r_target;
   assign w_to_de.stall          = w_stall_de;

   assign w_fe_bus = w_to_fe;
   assign w_de_bus = w_to_de;
   assign {stall_fe, redirect_valid, squash_fe_de, redirect_pc} = w_fe_bus;
   assign stall_de = w_de_bus[0];

`ifdef HAZARD_STATS_EN
   logic [31:0] r_raw_stall_cnt;
   logic [31:0] r_br_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_raw_stall_cnt <= '0;
         r_br_stall_cnt  <= '0;
      end else begin
         if ((r_state == ST_RUN) & w_stall_de) r_raw_stall_cnt <= r_raw_stall_cnt + 32'd1;
         if ((r_state == ST_BR_WAIT) | (r_state == ST_REDIRECT)) r_br_stall_cnt <= r_br_stall_cnt + 32'd1;
      end
   end

   assign raw_stall_cnt = r_raw_stall_cnt;
   assign br_stall_cnt  = r_br_stall_cnt;
`else
   assign raw_stall_cnt = '0;
   assign br_stall_cnt  = '0;
`endif

   a_resolve_in_wait: assert property (@(posedge clk) disable iff (reset)
      agex_br_resolve |-> (r_state == ST_BR_WAIT));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic vs. a behavioural model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   logic                 clk;
   logic                 reset;
   logic                 de_valid;
   logic [REG_IDX_W-1:0] de_src1, de_src2, de_dst;
   logic                 de_src1_used, de_src2_used, de_wr_en, de_is_br;
   logic                 agex_br_resolve, agex_br_taken;
   logic [PC_W-1:0]      agex_br_target;
   logic                 wb_valid, wb_wr_en;
   logic [REG_IDX_W-1:0] wb_dst;
   logic                 stall_fe, stall_de, redirect_valid, squash_fe_de;
   logic [PC_W-1:0]      redirect_pc;
   logic [NUM_REGS-1:0]  busy_vec;
   logic [31:0]          raw_stall_cnt, br_stall_cnt;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .de_valid(de_valid), .de_src1(de_src1), .de_src2(de_src2),
      .de_src1_used(de_src1_used), .de_src2_used(de_src2_used),
      .de_dst(de_dst), .de_wr_en(de_wr_en), .de_is_br(de_is_br),
      .agex_br_resolve(agex_br_resolve), .agex_br_taken(agex_br_taken),
      .agex_br_target(agex_br_target),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_wr_en(wb_wr_en),
      .stall_fe(stall_fe), .stall_de(stall_de), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .squash_fe_de(squash_fe_de), .busy_vec(busy_vec),
      .raw_stall_cnt(raw_stall_cnt), .br_stall_cnt(br_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: outstanding writes per register, branch phase flags, stats.
   int          m_cnt [NUM_REGS];
   bit          m_br_wait;
   bit          m_redirect;
   logic [31:0] m_target;
   logic [31:0] m_raw_stats;
   logic [31:0] m_br_stats;
   localparam int M_CNT_MAX = (1 << CNT_W) - 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic set_de(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input int dst, input bit we, input bit br);
      de_valid = v; de_src1 = REG_IDX_W'(s1); de_src1_used = u1;
      de_src2 = REG_IDX_W'(s2); de_src2_used = u2;
      de_dst = REG_IDX_W'(dst); de_wr_en = we; de_is_br = br;
   endtask

   task automatic set_wb(input bit v, input int dst, input bit we);
      wb_valid = v; wb_dst = REG_IDX_W'(dst); wb_wr_en = we;
   endtask

   task automatic set_br(input bit res, input bit tk, input logic [31:0] tgt);
      agex_br_resolve = res; agex_br_taken = tk; agex_br_target = tgt;
   endtask

   task automatic idle();
      set_de(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0);
      set_br(0, 0, 32'h0);
   endtask

   function automatic bit src_hazard(input int s, input bit used, input bit wbw, input int wbd);
      return used && m_cnt[s] > 0 && !(wbw && wbd == s && m_cnt[s] == 1);
   endfunction

   // Called at a negedge with inputs set: checks outputs, then advances the model across posedge.
   task automatic run_cycle();
      bit                  wbw, sat, e_sd, e_sf, e_rv, e_issue;
      logic [NUM_REGS-1:0] e_busy;
      logic [31:0]         e_raw, e_br;
      #1;
      wbw = wb_valid && wb_wr_en;
      sat = de_wr_en && m_cnt[de_dst] == M_CNT_MAX;
      if (m_redirect) begin
         e_sd = 1; e_sf = 0; e_rv = 1;
      end else if (m_br_wait) begin
         e_sd = 1; e_sf = 1; e_rv = 0;
      end else begin
         e_sd = de_valid && (src_hazard(int'(de_src1), de_src1_used, wbw, int'(wb_dst)) ||
                             src_hazard(int'(de_src2), de_src2_used, wbw, int'(wb_dst)) || sat);
         e_sf = e_sd; e_rv = 0;
      end
      for (int r = 0; r < NUM_REGS; r++) e_busy[r] = (m_cnt[r] != 0);
`ifdef HAZARD_STATS_EN
      e_raw = m_raw_stats; e_br = m_br_stats;
`else
      e_raw = 32'd0; e_br = 32'd0;
`endif
      if (!reset) begin
         check_eq("stall_fe", stall_fe, e_sf);
         check_eq("stall_de", stall_de, e_sd);
         check_eq("redirect_valid", redirect_valid, e_rv);
         check_eq("squash_fe_de", squash_fe_de, e_rv);
         check_eq("redirect_pc", redirect_pc, m_target);
         check_eq("busy_vec", busy_vec, e_busy);
         check_eq("raw_stall_cnt", raw_stall_cnt, e_raw);
         check_eq("br_stall_cnt", br_stall_cnt, e_br);
      end
      $display("cyc %0d rst=%b de=%b s%0d/%0d d%0d w%b br%b wb=%b/%0d res=%b%b stall=%b%b redir=%b busy=%h",
               cyc, reset, de_valid, de_src1, de_src2, de_dst, de_wr_en, de_is_br,
               wbw, wb_dst, agex_br_resolve, agex_br_taken, stall_fe, stall_de,
               redirect_valid, busy_vec);
      e_issue = de_valid && !e_sd;
      @(posedge clk);
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
         m_br_wait = 0; m_redirect = 0; m_target = '0;
         m_raw_stats = '0; m_br_stats = '0;
      end else begin
         if (!m_br_wait && !m_redirect && e_sd) m_raw_stats++;
         if (m_br_wait || m_redirect) m_br_stats++;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (e_issue && de_wr_en && int'(de_dst) == r) m_cnt[r]++;
            if (wbw && int'(wb_dst) == r) m_cnt[r]--;
         end
         if (m_redirect) begin
            m_redirect = 0;
         end else if (m_br_wait) begin
            if (agex_br_resolve) begin
               m_br_wait = 0;
               if (agex_br_taken) begin
                  m_redirect = 1;
                  m_target = agex_br_target;
               end
            end
         end else if (e_issue && de_is_br) begin
            m_br_wait = 1;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int busy_list[$];
      idle();
      reset = 1;
      @(negedge clk);
      run_cycle();
      run_cycle();
      reset = 0;

      // Scenario 1: RAW on r3 released by same-cycle WB.
      set_de(1, 0, 0, 0, 0, 3, 1, 0); run_cycle();
      set_de(1, 3, 1, 0, 0, 0, 0, 0);
      #1 check_eq("s1_raw_stall", stall_de, 1'b1);
      run_cycle();
      run_cycle();
      set_wb(1, 3, 1);
      #1 check_eq("s1_wb_release", stall_de, 1'b0);
      run_cycle();
      idle();
      #1 check_eq("s1_busy3", busy_vec[3], 1'b0);
      run_cycle();

      // Scenario 2: saturate r5, one WB releases the stall a cycle later.
      for (int i = 0; i < 3; i++) begin
         set_de(1, 0, 0, 0, 0, 5, 1, 0); run_cycle();
      end
      #1 check_eq("s2_sat_stall", stall_fe, 1'b1);
      run_cycle();
      set_wb(1, 5, 1); run_cycle();
      set_wb(0, 0, 0);
      #1 check_eq("s2_sat_release", stall_de, 1'b0);
      run_cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         set_wb(1, 5, 1); run_cycle();
      end
      idle();
      #1 check_eq("s2_busy5", busy_vec[5], 1'b0);
      run_cycle();

      // Scenario 3: simultaneous issue and WB of r7 leaves one write pending.
      set_de(1, 0, 0, 0, 0, 7, 1, 0); run_cycle();
      set_wb(1, 7, 1); run_cycle();
      idle();
      #1 check_eq("s3_busy7", busy_vec[7], 1'b1);
      set_wb(1, 7, 1); run_cycle();
      idle();
      #1 check_eq("s3_clear7", busy_vec[7], 1'b0);
      run_cycle();

      // Scenario 4: taken branch to 0x120.
      set_de(1, 0, 0, 0, 0, 0, 0, 1); run_cycle();
      set_de(1, 1, 1, 2, 1, 4, 1, 0);
      #1 check_eq("s4_hold_fe", stall_fe, 1'b1);
      run_cycle();
      run_cycle();
      set_br(1, 1, 32'h0000_0120); run_cycle();
      set_br(0, 0, 32'h0);
      #1 check_eq("s4_redir_pc", redirect_pc, 32'h0000_0120);
      check_eq("s4_redir_v", redirect_valid, 1'b1);
      run_cycle();
      idle(); run_cycle();

      // Scenario 5: not-taken branch.
      set_de(1, 0, 0, 0, 0, 0, 0, 1); run_cycle();
      idle(); run_cycle();
      set_br(1, 0, 32'hdead_beef); run_cycle();
      idle();
      #1 check_eq("s5_fe_free", stall_fe, 1'b0);
      check_eq("s5_no_redir", redirect_valid, 1'b0);
      run_cycle();

      // Scenario 6: reset while waiting on a branch that also writes r9.
      set_de(1, 0, 0, 0, 0, 9, 1, 1); run_cycle();
      idle(); run_cycle();
      reset = 1; run_cycle();
      reset = 0;
      #1 check_eq("s6_fe_free", stall_fe, 1'b0);
      check_eq("s6_busy", busy_vec, '0);
      run_cycle();

      // Random traffic, kept legal: WB only to pending registers, resolve only while waiting.
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         set_de($urandom_range(0, 9) < 7, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 1),
                $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 1),
                $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
         busy_list.delete();
         for (int r = 1; r < NUM_REGS; r++) if (m_cnt[r] > 0) busy_list.push_back(r);
         if (busy_list.size() > 0 && $urandom_range(0, 1) == 1)
            set_wb(1, busy_list[$urandom_range(0, busy_list.size() - 1)], 1);
         else
            set_wb($urandom_range(0, 1), $urandom_range(0, NUM_REGS - 1), 0);
         if (m_br_wait && $urandom_range(0, 2) == 0)
            set_br(1, $urandom_range(0, 1), $urandom);
         else
            set_br(0, $urandom_range(0, 1), $urandom);
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
